// File: rtl/cmul_sched_pkg.sv
// rtl/cmul_sched_pkg.sv - shared types and constants for the complex-multiply sequencer
package cmul_sched_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_FRACTION  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] P_RR = 2'd0;
  localparam logic [1:0] P_II = 2'd1;
  localparam logic [1:0] P_RI = 2'd2;
  localparam logic [1:0] P_IR = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } tag_t;

endpackage

// File: rtl/cmul_tag_pipe.sv
// rtl/cmul_tag_pipe.sv - DEPTH-stage {valid, index} tag shift register tracking products in flight
module cmul_tag_pipe
  import cmul_sched_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign o_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/cmul_sched.sv
// rtl/cmul_sched.sv - schedules one shared real multiplier to form a complex product per request
// Optional saturating result with o_sat flag when CMUL_SAT_EN is defined.
module cmul_sched
  import cmul_sched_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int FRACTION    = DEF_FRACTION,
  parameter int MUL_LATENCY = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD_SIZE-1:0] i_ar,
  input  logic [WORD_SIZE-1:0] i_ai,
  input  logic [WORD_SIZE-1:0] i_br,
  input  logic [WORD_SIZE-1:0] i_bi,
  output logic [WORD_SIZE-1:0] o_mul_a,
  output logic [WORD_SIZE-1:0] o_mul_b,
  input  logic [WORD_SIZE-1:0] i_mul_p,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [WORD_SIZE-1:0] o_re,
`ifdef CMUL_SAT_EN
  output logic [WORD_SIZE-1:0] o_im,
  output logic                 o_sat
`else
  output logic [WORD_SIZE-1:0] o_im
`endif
);

  if (MUL_LATENCY < 1 || MUL_LATENCY > 8 || FRACTION < 0 || FRACTION >= WORD_SIZE) begin : g_param_check
    $error("cmul_sched: MUL_LATENCY or FRACTION out of range");
  end

  state_e               state_q, state_d;
  logic [1:0]           k_q, k_d;
  logic [WORD_SIZE-1:0] ar_q, ai_q, br_q, bi_q;
  logic [WORD_SIZE-1:0] p0_q, p1_q, p2_q;
  logic [WORD_SIZE-1:0] re_q, im_q;
  logic [WORD_SIZE-1:0] re_d, im_d;
  logic                 accept;
  logic                 p3_hit;
  tag_t                 tag_in, tag_out;

  cmul_tag_pipe #(
    .DEPTH(MUL_LATENCY)
  ) u_tag_pipe (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_tag(tag_in),
    .o_tag(tag_out)
  );

  // The last product (ai*br) arrives straight from the multiplier and is combined in the same cycle.
  assign p3_hit = tag_out.valid && (tag_out.idx == P_IR) && (state_q == DRAIN);

  assign o_ready = (state_q == IDLE) && !i_rst;
  assign o_valid = (state_q == DONE);
  assign o_re    = re_q;
  assign o_im    = im_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    accept     = 1'b0;
    tag_in     = '0;
    o_mul_a    = '0;
    o_mul_b    = '0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          accept  = 1'b1;
          k_d     = P_RR;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tag_in.valid = 1'b1;
        tag_in.idx   = k_q;
        case (k_q)
          P_RR:    begin o_mul_a = ar_q; o_mul_b = br_q; end
          P_II:    begin o_mul_a = ai_q; o_mul_b = bi_q; end
          P_RI:    begin o_mul_a = ar_q; o_mul_b = bi_q; end
          default: begin o_mul_a = ai_q; o_mul_b = br_q; end
        endcase
        k_d = k_q + 2'd1;
        if (k_q == P_IR) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (p3_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CMUL_SAT_EN
  localparam logic [WORD_SIZE-1:0] SAT_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic [WORD_SIZE-1:0] SAT_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

  logic [WORD_SIZE:0] re_wide, im_wide;
  logic               re_ovf, im_ovf;
  logic               sat_q, sat_d;

  always_comb begin
    re_wide = {p0_q[WORD_SIZE-1], p0_q} - {p1_q[WORD_SIZE-1], p1_q};
    im_wide = {p2_q[WORD_SIZE-1], p2_q} + {i_mul_p[WORD_SIZE-1], i_mul_p};
    re_ovf  = re_wide[WORD_SIZE] ^ re_wide[WORD_SIZE-1];
    im_ovf  = im_wide[WORD_SIZE] ^ im_wide[WORD_SIZE-1];
    re_d    = re_ovf ? (re_wide[WORD_SIZE] ? SAT_MIN : SAT_MAX) : re_wide[WORD_SIZE-1:0];
    im_d    = im_ovf ? (im_wide[WORD_SIZE] ? SAT_MIN : SAT_MAX) : im_wide[WORD_SIZE-1:0];
    sat_d   = re_ovf || im_ovf;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sat_q <= 1'b0;
    end else if (p3_hit) begin
      sat_q <= sat_d;
    end else if (state_q == DONE && i_out_ready) begin
      sat_q <= 1'b0;
    end
  end

  assign o_sat = sat_q;
`else
  always_comb begin
    re_d = p0_q - p1_q;
    im_d = p2_q + i_mul_p;
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        ar_q <= i_ar;
        ai_q <= i_ai;
        br_q <= i_br;
        bi_q <= i_bi;
      end
      // Products without a valid exiting tag are ignored.
      if (tag_out.valid) begin
        case (tag_out.idx)
          P_RR:    p0_q <= i_mul_p;
          P_II:    p1_q <= i_mul_p;
          P_RI:    p2_q <= i_mul_p;
          default: ;
        endcase
      end
      if (p3_hit) begin
        re_q <= re_d;
        im_q <= im_d;
      end
    end
  end

endmodule

// File: tb/tb_cmul_sched.sv
// tb/tb_cmul_sched.sv - scoreboard bench for cmul_sched with a Q8.8 pipelined multiplier model
module tb_cmul_sched;

  localparam int W = 16;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] ar, ai, br, bi;
  logic [W-1:0] o_mul_a, o_mul_b;
  logic [W-1:0] mul_p;
  logic         o_valid;
  logic         out_ready;
  logic [W-1:0] o_re, o_im;
`ifdef CMUL_SAT_EN
  logic         o_sat;
`endif

  cmul_sched #(
    .WORD_SIZE(W),
    .FRACTION(8),
    .MUL_LATENCY(L)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_ar(ar),
    .i_ai(ai),
    .i_br(br),
    .i_bi(bi),
    .o_mul_a(o_mul_a),
    .o_mul_b(o_mul_b),
    .i_mul_p(mul_p),
    .o_valid(o_valid),
    .i_out_ready(out_ready),
    .o_re(o_re),
`ifdef CMUL_SAT_EN
    .o_im(o_im),
    .o_sat(o_sat)
`else
    .o_im(o_im)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mulq(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [31:0] pr;
    pr = $signed(a) * $signed(b);
    return pr[23:8];
  endfunction

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sat;
  } exp_t;

  function automatic logic [W-1:0] clamp(input int v, output logic s);
    s = 1'b0;
    if (v > 32767) begin s = 1'b1; return 16'h7FFF; end
    if (v < -32768) begin s = 1'b1; return 16'h8000; end
    return v[W-1:0];
  endfunction

  function automatic exp_t model(input logic [W-1:0] xar, input logic [W-1:0] xai,
                                 input logic [W-1:0] xbr, input logic [W-1:0] xbi);
    exp_t e;
    logic [W-1:0] p0, p1, p2, p3;
    logic s0, s1;
    p0 = mulq(xar, xbr);
    p1 = mulq(xai, xbi);
    p2 = mulq(xar, xbi);
    p3 = mulq(xai, xbr);
`ifdef CMUL_SAT_EN
    e.re  = clamp(int'($signed(p0)) - int'($signed(p1)), s0);
    e.im  = clamp(int'($signed(p2)) + int'($signed(p3)), s1);
    e.sat = s0 | s1;
`else
    s0 = 1'b0;
    s1 = 1'b0;
    e.re  = p0 - p1;
    e.im  = p2 + p3;
    e.sat = s0 | s1;
`endif
    return e;
  endfunction

  // Multiplier model: operands seen in cycle c appear on mul_p in cycle c+L.
  logic [W-1:0] mp [L];
  always @(posedge clk) begin
    mp[0] <= mulq(o_mul_a, o_mul_b);
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  assign mul_p = mp[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t         exp_q[$];
  int           acc_cyc = 0;
  int           n_acc = 0;
  int           n_pop = 0;
  bit           trk = 1'b0;
  bit           ov_prev = 1'b0;
  int           rel;
  logic [W-1:0] s_ar, s_ai, s_br, s_bi;
  exp_t         got;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      trk     = 1'b0;
      ov_prev = 1'b0;
    end else begin
      if (trk) begin
        rel = cyc - acc_cyc;
        case (rel)
          1: begin check_eq("mul_k0_a", o_mul_a, s_ar); check_eq("mul_k0_b", o_mul_b, s_br); end
          2: begin check_eq("mul_k1_a", o_mul_a, s_ai); check_eq("mul_k1_b", o_mul_b, s_bi); end
          3: begin check_eq("mul_k2_a", o_mul_a, s_ar); check_eq("mul_k2_b", o_mul_b, s_bi); end
          4: begin check_eq("mul_k3_a", o_mul_a, s_ai); check_eq("mul_k3_b", o_mul_b, s_br); end
          5: begin check_eq("mul_post_a", o_mul_a, 0); check_eq("mul_post_b", o_mul_b, 0); end
          default: ;
        endcase
      end
      if (o_valid && !ov_prev) check_eq("latency", cyc - acc_cyc, 5 + L);
      ov_prev = o_valid;
      if (o_valid && out_ready) begin
        check_eq("q_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          check_eq("re", o_re, got.re);
          check_eq("im", o_im, got.im);
`ifdef CMUL_SAT_EN
          check_eq("sat", o_sat, got.sat);
`endif
        end
        n_pop++;
      end
      if (i_valid && o_ready) begin
        check_eq("mul_idle_a", o_mul_a, 0);
        check_eq("mul_idle_b", o_mul_b, 0);
        acc_cyc = cyc;
        trk     = 1'b1;
        s_ar = ar; s_ai = ai; s_br = br; s_bi = bi;
        exp_q.push_back(model(ar, ai, br, bi));
        n_acc++;
      end
    end
  end

  task automatic send(input logic [W-1:0] xar, input logic [W-1:0] xai,
                      input logic [W-1:0] xbr, input logic [W-1:0] xbi);
    int start;
    start = n_acc;
    ar = xar; ai = xai; br = xbr; bi = xbi;
    i_valid = 1'b1;
    for (int i = 0; i < 100 && n_acc == start; i++) begin
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check_eq("accepted", n_acc, start + 1);
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 200 && n_pop < n; i++) begin
      @(posedge clk); #1;
    end
    check_eq("pops", n_pop, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  exp_t e;
  int   a_cyc;

  initial begin
    rst = 1'b1; i_valid = 1'b0; out_ready = 1'b1;
    ar = '0; ai = '0; br = '0; bi = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", o_ready, 0);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_re", o_re, 0);
    check_eq("rst_mul_a", o_mul_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_after_rst", o_ready, 1);

    send(16'h0100, 16'h0100, 16'h0080, 16'hFF80);
    wait_pops(1);
    send(16'h6000, 16'hA000, 16'h0100, 16'h0100);
    wait_pops(2);
    for (int i = 0; i < 3; i++) begin
      send(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
           W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)));
    end
    wait_pops(5);

    out_ready = 1'b0;
    send(16'h0300, 16'hFE00, 16'h0140, 16'h0020);
    e = model(16'h0300, 16'hFE00, 16'h0140, 16'h0020);
    for (int i = 0; i < 50 && !o_valid; i++) begin
      @(posedge clk); #1;
    end
    check_eq("bp_valid_seen", o_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", o_valid, 1);
      check_eq("bp_re", o_re, e.re);
      check_eq("bp_im", o_im, e.im);
      check_eq("bp_ready", o_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_valid_drop", o_valid, 0);
    check_eq("bp_ready_rise", o_ready, 1);
    wait_pops(6);

    send(16'h0180, 16'h0040, 16'hFF00, 16'h0200);
    a_cyc = acc_cyc;
    ar = 16'h0500; ai = 16'h0100; br = 16'h0100; bi = 16'h0300;
    i_valid = 1'b1;
    for (int i = 0; i < 60 && n_acc == 6 + 1; i++) begin
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check_eq("second_accepted", n_acc, 8);
    check_eq("second_gap", acc_cyc - a_cyc, 6 + L);
    wait_pops(8);

    send(16'h0240, 16'h0110, 16'h0090, 16'hFFA0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", o_valid, 0);
    check_eq("mid_rst_re", o_re, 0);
    check_eq("mid_rst_im", o_im, 0);
    check_eq("mid_rst_ready", o_ready, 0);
    check_eq("mid_rst_mul_a", o_mul_a, 0);
    check_eq("mid_rst_mul_b", o_mul_b, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(16'h0200, 16'h0000, 16'h0200, 16'h0000);
    wait_pops(9);
    check_eq("post_rst_re", o_re, 16'h0400);
    check_eq("post_rst_im", o_im, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    check_eq("idle_valid", o_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
